// File: rtl/serial_adder_pkg.sv
// Shared state encoding and default operand width for the bit-serial adder.
package serial_adder_pkg;

  localparam int unsigned DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADD  = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/full_adder.sv
// One-bit full adder built from two half adders and an OR of their carries.
module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s_c,
  output logic cout_c
);

  logic p;
  logic g0;
  logic g1;

  half_adder u_ha0 (.a(a), .b(b),   .s_c(p),   .c_c(g0));
  half_adder u_ha1 (.a(p), .b(cin), .s_c(s_c), .c_c(g1));

  assign cout_c = g0 | g1;

endmodule

// File: rtl/half_adder.sv
// One-bit half adder: sum and carry of two bits.
module half_adder (
  input  logic a,
  input  logic b,
  output logic s_c,
  output logic c_c
);

  assign s_c = a ^ b;
  assign c_c = a & b;

endmodule

// File: rtl/serial_adder.sv
// Bit-serial unsigned adder: one bit per clock, LSB first, result published
// on entry to DONE together with a one-cycle done pulse.
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic             start_in,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  input  logic             cin_in,
  output logic             busy_out,
  output logic             done_out,
  output logic [WIDTH-1:0] sum_out,
  output logic             carry_out
);

  localparam int unsigned CNT_W = $clog2(WIDTH + 1);

  state_e             state;
  state_e             state_next;
  logic [WIDTH-1:0]   a_sr;
  logic [WIDTH-1:0]   b_sr;
  logic [WIDTH-1:0]   sum_sr;
  logic [WIDTH-1:0]   sum_next;
  logic               carry_q;
  logic [CNT_W-1:0]   cnt;
  logic               load;
  logic               step;
  logic               finish;
  logic               fa_s;
  logic               fa_c;

  full_adder u_fa (
    .a     (a_sr[0]),
    .b     (b_sr[0]),
    .cin   (carry_q),
    .s_c   (fa_s),
    .cout_c(fa_c)
  );

  // New sum bit enters at the MSB so the word is aligned after WIDTH steps.
  assign sum_next = (sum_sr >> 1) | {fa_s, {(WIDTH-1){1'b0}}};

  // Next-state and datapath strobes.
  always_comb begin
    state_next = state;
    load       = 1'b0;
    step       = 1'b0;
    finish     = 1'b0;
    case (state)
      IDLE: begin
        if (start_in) begin
          state_next = ADD;
          load       = 1'b1;
        end
      end
      ADD: begin
        step = 1'b1;
        if (cnt == CNT_W'(WIDTH - 1)) begin
          state_next = DONE;
          finish     = 1'b1;
        end
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // State, datapath and output registers.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state     <= IDLE;
      a_sr      <= '0;
      b_sr      <= '0;
      sum_sr    <= '0;
      carry_q   <= 1'b0;
      cnt       <= '0;
      busy_out  <= 1'b0;
      done_out  <= 1'b0;
      sum_out   <= '0;
      carry_out <= 1'b0;
    end else begin
      state    <= state_next;
      busy_out <= (state_next != IDLE);
      done_out <= (state_next == DONE);
      if (load) begin
        a_sr    <= a_in;
        b_sr    <= b_in;
        carry_q <= cin_in;
        cnt     <= '0;
      end
      if (step) begin
        a_sr    <= a_sr >> 1;
        b_sr    <= b_sr >> 1;
        sum_sr  <= sum_next;
        carry_q <= fa_c;
        cnt     <= cnt + CNT_W'(1);
      end
      if (finish) begin
        sum_out   <= sum_next;
        carry_out <= fa_c;
      end
    end
  end

endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder (WIDTH=8) against an arithmetic model.
module tb_serial_adder;

  localparam int unsigned W = 8;

  logic         clk;
  logic         rst;
  logic         start;
  logic [W-1:0] a_in;
  logic [W-1:0] b_in;
  logic         cin;
  logic         busy;
  logic         done;
  logic [W-1:0] sum;
  logic         carry;

  int n_cmp  = 0;
  int n_fail = 0;

  serial_adder #(.WIDTH(W)) dut (
    .clk_in   (clk),
    .rst_in   (rst),
    .start_in (start),
    .a_in     (a_in),
    .b_in     (b_in),
    .cin_in   (cin),
    .busy_out (busy),
    .done_out (done),
    .sum_out  (sum),
    .carry_out(carry)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Reference: unsigned (WIDTH+1)-bit sum, carry in the top bit.
  function automatic logic [W:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                       input logic c);
    return (W+1)'(a) + (W+1)'(b) + (W+1)'(c);
  endfunction

  // Launch one operation and observe it for a bounded window; inputs are
  // scrambled right after the accept edge.
  task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic c,
                       output int lat, output int busy_cnt, output int pulses,
                       output logic [W-1:0] s_obs, output logic c_obs);
    lat = -1; busy_cnt = 0; pulses = 0; s_obs = 'x; c_obs = 1'bx;
    @(negedge clk);
    start = 1'b1; a_in = a; b_in = b; cin = c;
    @(posedge clk);
    #1;
    start = 1'b0;
    a_in = W'($urandom); b_in = W'($urandom); cin = 1'($urandom);
    for (int cyc = 1; cyc <= W + 6; cyc++) begin
      @(negedge clk);
      if (busy) busy_cnt++;
      if (done) begin
        pulses++;
        if (lat < 0) begin
          lat = cyc - 1;
          s_obs = sum;
          c_obs = carry;
        end
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; a_in = '0; b_in = '0; cin = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    n_cmp++; if (busy !== 1'b0)  begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
    n_cmp++; if (done !== 1'b0)  begin n_fail++; $display("FAIL reset_done: got %b want 0", done); end
    n_cmp++; if (sum !== '0)     begin n_fail++; $display("FAIL reset_sum: got %h want 00", sum); end
    n_cmp++; if (carry !== 1'b0) begin n_fail++; $display("FAIL reset_carry: got %b want 0", carry); end
  endtask

  task automatic test_directed(input string name, input logic [W-1:0] a,
                               input logic [W-1:0] b, input logic c);
    int lat, bc, pc;
    logic [W-1:0] s;
    logic co;
    logic [W:0] exp;
    exp = model(a, b, c);
    do_op(a, b, c, lat, bc, pc, s, co);
    n_cmp++; if (lat !== W)      begin n_fail++; $display("FAIL %s_latency: got %0d want %0d", name, lat, W); end
    n_cmp++; if (bc !== W + 1)   begin n_fail++; $display("FAIL %s_busy_cycles: got %0d want %0d", name, bc, W + 1); end
    n_cmp++; if (pc !== 1)       begin n_fail++; $display("FAIL %s_pulses: got %0d want 1", name, pc); end
    n_cmp++; if (s !== exp[W-1:0]) begin n_fail++; $display("FAIL %s_sum: got %h want %h", name, s, exp[W-1:0]); end
    n_cmp++; if (co !== exp[W])  begin n_fail++; $display("FAIL %s_carry: got %b want %b", name, co, exp[W]); end
  endtask

  task automatic test_busy_restart();
    int bc = 0;
    int pc = 0;
    int got = 0;
    logic [W:0] exp;
    logic [W-1:0] aa;
    aa = 8'hAA;
    exp = model(aa, aa, 1'b0);
    @(negedge clk);
    start = 1'b1; a_in = 8'h0F; b_in = 8'h01; cin = 1'b0;
    @(posedge clk);
    #1 a_in = aa; b_in = aa;
    for (int cyc = 1; cyc <= W + 1; cyc++) begin
      @(negedge clk);
      if (busy) bc++;
      if (done) pc++;
    end
    n_cmp++; if (bc !== W + 1) begin n_fail++; $display("FAIL hold_start_busy: got %0d want %0d", bc, W + 1); end
    n_cmp++; if (pc !== 1)     begin n_fail++; $display("FAIL hold_start_pulses: got %0d want 1", pc); end
    n_cmp++; if (sum !== 8'h10) begin n_fail++; $display("FAIL hold_start_sum: got %h want 10", sum); end
    @(negedge clk);
    n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL restart_idle_busy: got %b want 0", busy); end
    n_cmp++; if (done !== 1'b0) begin n_fail++; $display("FAIL restart_idle_done: got %b want 0", done); end
    @(posedge clk);
    #1 start = 1'b0; a_in = W'($urandom); b_in = W'($urandom);
    @(negedge clk);
    n_cmp++; if (busy !== 1'b1) begin n_fail++; $display("FAIL restart_busy: got %b want 1", busy); end
    for (int cyc = 0; cyc < W + 6 && got == 0; cyc++) begin
      @(negedge clk);
      if (done) got = 1;
    end
    n_cmp++; if (got !== 1) begin n_fail++; $display("FAIL restart_done: got %0d want 1", got); end
    n_cmp++; if (sum !== exp[W-1:0]) begin n_fail++; $display("FAIL restart_sum: got %h want %h", sum, exp[W-1:0]); end
    n_cmp++; if (carry !== exp[W])   begin n_fail++; $display("FAIL restart_carry: got %b want %b", carry, exp[W]); end
  endtask

  task automatic test_reset_mid();
    int pc = 0;
    @(negedge clk);
    start = 1'b1; a_in = 8'h37; b_in = 8'h44; cin = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (3) @(negedge clk);
    @(negedge clk);
    rst = 1'b1; start = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0; start = 1'b0;
    @(negedge clk);
    n_cmp++; if (busy !== 1'b0)  begin n_fail++; $display("FAIL midrst_busy: got %b want 0", busy); end
    n_cmp++; if (done !== 1'b0)  begin n_fail++; $display("FAIL midrst_done: got %b want 0", done); end
    n_cmp++; if (sum !== '0)     begin n_fail++; $display("FAIL midrst_sum: got %h want 00", sum); end
    n_cmp++; if (carry !== 1'b0) begin n_fail++; $display("FAIL midrst_carry: got %b want 0", carry); end
    for (int cyc = 0; cyc < W + 4; cyc++) begin
      @(negedge clk);
      if (done || busy) pc++;
    end
    n_cmp++; if (pc !== 0) begin n_fail++; $display("FAIL midrst_activity: got %0d want 0", pc); end
    test_directed("after_reset", 8'h01, 8'h01, 1'b0);
  endtask

  task automatic test_hold();
    logic [W-1:0] s0;
    logic c0;
    s0 = sum; c0 = carry;
    for (int cyc = 0; cyc < 20; cyc++) begin
      a_in = W'($urandom); b_in = W'($urandom); cin = 1'($urandom);
      @(negedge clk);
      n_cmp++; if (sum !== s0)    begin n_fail++; $display("FAIL hold_sum[%0d]: got %h want %h", cyc, sum, s0); end
      n_cmp++; if (carry !== c0)  begin n_fail++; $display("FAIL hold_carry[%0d]: got %b want %b", cyc, carry, c0); end
      n_cmp++; if (done !== 1'b0) begin n_fail++; $display("FAIL hold_done[%0d]: got %b want 0", cyc, done); end
    end
  endtask

  task automatic test_random();
    int lat, bc, pc;
    logic [W-1:0] s, a, b;
    logic co, c;
    logic [W:0] exp;
    for (int i = 0; i < 25; i++) begin
      a = W'($urandom); b = W'($urandom); c = 1'($urandom);
      exp = model(a, b, c);
      do_op(a, b, c, lat, bc, pc, s, co);
      n_cmp++; if (lat !== W) begin n_fail++; $display("FAIL rand%0d_latency: got %0d want %0d", i, lat, W); end
      n_cmp++; if ({co, s} !== exp) begin
        n_fail++; $display("FAIL rand%0d_result: %h+%h+%b got %b_%h want %b_%h", i, a, b, c, co, s, exp[W], exp[W-1:0]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_directed("basic", 8'h5A, 8'h3C, 1'b0);
    test_directed("overflow", 8'hFF, 8'h01, 1'b0);
    test_directed("carry_in", 8'hFF, 8'hFF, 1'b1);
    test_busy_restart();
    test_reset_mid();
    test_hold();
    test_random();
    test_hold();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
